// File: rtl/reserv_station_if.sv
// Dispatch, result-broadcast and issue signals of one reservation station.
// master drives dispatch/broadcast/iss_ready; slave is the station itself.
interface reserv_station_if #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned BCAST_N = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned OP_W    = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                      flush;
  logic                      in_ce;
  logic [TAG_W-1:0]          in_target;
  logic [OP_W-1:0]           in_op;
  logic [NUM_SRC*DATA_W-1:0] in_val;
  logic [NUM_SRC*TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0]         in_pc;
  logic                      full;
  logic [CNT_W-1:0]          count;
  logic [BCAST_N-1:0]        bc_valid;
  logic [BCAST_N*TAG_W-1:0]  bc_tag;
  logic [BCAST_N*DATA_W-1:0] bc_data;
  logic                      iss_valid;
  logic                      iss_ready;
  logic [TAG_W-1:0]          iss_target;
  logic [OP_W-1:0]           iss_op;
  logic [NUM_SRC*DATA_W-1:0] iss_val;
  logic [DATA_W-1:0]         iss_pc;

  modport master (
    output flush, in_ce, in_target, in_op, in_val, in_tag, in_pc,
    output bc_valid, bc_tag, bc_data, iss_ready,
    input  full, count, iss_valid, iss_target, iss_op, iss_val, iss_pc
  );

  modport slave (
    input  flush, in_ce, in_target, in_op, in_val, in_tag, in_pc,
    input  bc_valid, bc_tag, bc_data, iss_ready,
    output full, count, iss_valid, iss_target, iss_op, iss_val, iss_pc
  );
endinterface

// File: rtl/reserv_station.sv
// Reservation station: DEPTH entries snooping BCAST_N result buses, issuing the oldest ready op.
// Define RS_WAKEUP_BYPASS_EN to let an op issue in the same cycle its last operand is broadcast.
module reserv_station #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned BCAST_N = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned OP_W    = 4
) (
  input logic             clk,
  input logic             rst,
  reserv_station_if.slave rs
);
  localparam logic [TAG_W-1:0] TAG_INVALID = '1;
  localparam int unsigned      CNT_W       = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tgt_q [DEPTH], tgt_d [DEPTH];
  logic [OP_W-1:0]   op_q  [DEPTH], op_d  [DEPTH];
  logic [DATA_W-1:0] pc_q  [DEPTH], pc_d  [DEPTH];
  logic [TAG_W-1:0]  tag_q [DEPTH][NUM_SRC], tag_d [DEPTH][NUM_SRC];
  logic [DATA_W-1:0] val_q [DEPTH][NUM_SRC], val_d [DEPTH][NUM_SRC];
  // older_q[i][j] is set when entry i was dispatched before entry j
  logic [DEPTH-1:0]  older_q [DEPTH], older_d [DEPTH];

  logic                      iss_valid_q, iss_valid_d;
  logic [TAG_W-1:0]          iss_target_q, iss_target_d;
  logic [OP_W-1:0]           iss_op_q, iss_op_d;
  logic [NUM_SRC*DATA_W-1:0] iss_val_q, iss_val_d;
  logic [DATA_W-1:0]         iss_pc_q, iss_pc_d;

  logic [NUM_SRC-1:0] hit [DEPTH];
  logic [DATA_W-1:0]  eff_val [DEPTH][NUM_SRC];
  logic [NUM_SRC-1:0] in_hit;
  logic [DATA_W-1:0]  in_data [NUM_SRC];
  logic [DEPTH-1:0]   cand, sel, free_oh;
  logic [CNT_W-1:0]   cnt;
  logic               full, accept, move;

  // Broadcast snoop; eff_val is the operand value as it will be after this edge
  always_comb begin
    logic found;
    for (int e = 0; e < DEPTH; e++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        found         = 1'b0;
        eff_val[e][s] = val_q[e][s];
        for (int c = 0; c < BCAST_N; c++) begin
          if (!found && valid_q[e] && tag_q[e][s] != TAG_INVALID && rs.bc_valid[c] &&
              rs.bc_tag[c*TAG_W +: TAG_W] == tag_q[e][s]) begin
            found         = 1'b1;
            eff_val[e][s] = rs.bc_data[c*DATA_W +: DATA_W];
          end
        end
        hit[e][s] = found;
      end
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      found      = 1'b0;
      in_data[s] = rs.in_val[s*DATA_W +: DATA_W];
      for (int c = 0; c < BCAST_N; c++) begin
        if (!found && rs.in_tag[s*TAG_W +: TAG_W] != TAG_INVALID && rs.bc_valid[c] &&
            rs.bc_tag[c*TAG_W +: TAG_W] == rs.in_tag[s*TAG_W +: TAG_W]) begin
          found      = 1'b1;
          in_data[s] = rs.bc_data[c*DATA_W +: DATA_W];
        end
      end
      in_hit[s] = found;
    end
  end

  always_comb begin
    logic found;
    for (int e = 0; e < DEPTH; e++) begin
      cand[e] = valid_q[e];
      for (int s = 0; s < NUM_SRC; s++) begin
`ifdef RS_WAKEUP_BYPASS_EN
        if (tag_q[e][s] != TAG_INVALID && !hit[e][s]) cand[e] = 1'b0;
`else
        if (tag_q[e][s] != TAG_INVALID) cand[e] = 1'b0;
`endif
      end
    end
    sel = cand;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (i != j && cand[j] && older_q[j][i]) sel[i] = 1'b0;
      end
    end
    free_oh = '0;
    found   = 1'b0;
    cnt     = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (!valid_q[e] && !found) begin
        free_oh[e] = 1'b1;
        found      = 1'b1;
      end
      cnt = cnt + CNT_W'(valid_q[e]);
    end
  end

  assign full   = (cnt == CNT_W'(DEPTH));
  assign accept = rs.in_ce && (rs.in_target != TAG_INVALID) && !full && !rs.flush;
  assign move   = (|cand) && (!iss_valid_q || rs.iss_ready);

  always_comb begin
    valid_d      = valid_q;
    tgt_d        = tgt_q;
    op_d         = op_q;
    pc_d         = pc_q;
    tag_d        = tag_q;
    val_d        = val_q;
    older_d      = older_q;
    iss_valid_d  = iss_valid_q;
    iss_target_d = iss_target_q;
    iss_op_d     = iss_op_q;
    iss_val_d    = iss_val_q;
    iss_pc_d     = iss_pc_q;

    for (int e = 0; e < DEPTH; e++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (hit[e][s]) begin
          tag_d[e][s] = TAG_INVALID;
          val_d[e][s] = eff_val[e][s];
        end
      end
    end

    if (move) begin
      iss_valid_d = 1'b1;
      for (int e = 0; e < DEPTH; e++) begin
        if (sel[e]) begin
          valid_d[e]   = 1'b0;
          iss_target_d = tgt_q[e];
          iss_op_d     = op_q[e];
          iss_pc_d     = pc_q[e];
          for (int s = 0; s < NUM_SRC; s++) iss_val_d[s*DATA_W +: DATA_W] = eff_val[e][s];
        end
      end
    end else if (iss_valid_q && rs.iss_ready) begin
      iss_valid_d = 1'b0;
    end

    for (int e = 0; e < DEPTH; e++) begin
      if (accept && free_oh[e]) begin
        valid_d[e] = 1'b1;
        tgt_d[e]   = rs.in_target;
        op_d[e]    = rs.in_op;
        pc_d[e]    = rs.in_pc;
        older_d[e] = '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (j != e) older_d[j][e] = 1'b1;
        end
        for (int s = 0; s < NUM_SRC; s++) begin
          tag_d[e][s] = in_hit[s] ? TAG_INVALID : rs.in_tag[s*TAG_W +: TAG_W];
          val_d[e][s] = in_data[s];
        end
      end
    end

    if (rs.flush) begin
      valid_d     = '0;
      iss_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      iss_valid_q  <= 1'b0;
      iss_target_q <= TAG_INVALID;
      iss_op_q     <= '0;
      iss_val_q    <= '0;
      iss_pc_q     <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        tgt_q[e]   <= TAG_INVALID;
        op_q[e]    <= '0;
        pc_q[e]    <= '0;
        older_q[e] <= '0;
        for (int s = 0; s < NUM_SRC; s++) begin
          tag_q[e][s] <= TAG_INVALID;
          val_q[e][s] <= '0;
        end
      end
    end else begin
      valid_q      <= valid_d;
      tgt_q        <= tgt_d;
      op_q         <= op_d;
      pc_q         <= pc_d;
      tag_q        <= tag_d;
      val_q        <= val_d;
      older_q      <= older_d;
      iss_valid_q  <= iss_valid_d;
      iss_target_q <= iss_target_d;
      iss_op_q     <= iss_op_d;
      iss_val_q    <= iss_val_d;
      iss_pc_q     <= iss_pc_d;
    end
  end

  assign rs.full       = full;
  assign rs.count      = cnt;
  assign rs.iss_valid  = iss_valid_q;
  assign rs.iss_target = iss_target_q;
  assign rs.iss_op     = iss_op_q;
  assign rs.iss_val    = iss_val_q;
  assign rs.iss_pc     = iss_pc_q;
endmodule

// File: tb/tb_reserv_station.sv
// Bench for reserv_station: directed scenarios plus random traffic against a queue-based model.
// Honours RS_WAKEUP_BYPASS_EN in both the model and the latency expectations.
module tb_reserv_station;
  localparam int DEPTH   = 4;
  localparam int NUM_SRC = 2;
  localparam int BCAST_N = 2;
  localparam logic [4:0] INV = 5'h1f;

  typedef struct packed {
    logic [4:0]  target;
    logic [3:0]  op;
    logic [31:0] pc;
    logic [63:0] val;
    logic [9:0]  tag;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  ent_t q[$];          // pending entries, oldest first
  ent_t m_iss;
  logic m_iss_v = 1'b0;
  int   order[$];

  always #5 clk = ~clk;

  reserv_station_if #(.DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .BCAST_N(BCAST_N), .DATA_W(32),
                      .TAG_W(5), .OP_W(4)) bus ();

  reserv_station #(.DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .BCAST_N(BCAST_N), .DATA_W(32),
                   .TAG_W(5), .OP_W(4)) dut (.clk(clk), .rst(rst), .rs(bus));

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // First valid channel carrying tag t wins
  function automatic void bc_lookup(input logic [4:0] t, input logic [1:0] bv,
                                    input logic [9:0] bt, input logic [63:0] bd,
                                    output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (t != INV) begin
      for (int c = 0; c < BCAST_N; c++) begin
        if (!hit && bv[c] && bt[c*5 +: 5] == t) begin
          hit = 1'b1;
          d   = bd[c*32 +: 32];
        end
      end
    end
  endfunction

  always @(posedge clk) begin : model
    int          sel;
    logic        ok, hit, full_pre;
    logic [31:0] d;
    ent_t        e;
    if (rst || bus.flush) begin
      q.delete();
      m_iss_v = 1'b0;
    end else begin
      full_pre = (q.size() == DEPTH);
      sel = -1;
      for (int i = 0; i < q.size(); i++) begin
        if (sel < 0) begin
          ok = 1'b1;
          for (int s = 0; s < NUM_SRC; s++) begin
            if (q[i].tag[s*5 +: 5] != INV) begin
`ifdef RS_WAKEUP_BYPASS_EN
              bc_lookup(q[i].tag[s*5 +: 5], bus.bc_valid, bus.bc_tag, bus.bc_data, hit, d);
              if (!hit) ok = 1'b0;
`else
              ok = 1'b0;
`endif
            end
          end
          if (ok) sel = i;
        end
      end
      if (sel >= 0 && (!m_iss_v || bus.iss_ready)) begin
        e = q[sel];
        for (int s = 0; s < NUM_SRC; s++) begin
          if (e.tag[s*5 +: 5] != INV) begin
            bc_lookup(e.tag[s*5 +: 5], bus.bc_valid, bus.bc_tag, bus.bc_data, hit, d);
            e.val[s*32 +: 32] = d;
          end
        end
        m_iss   = e;
        m_iss_v = 1'b1;
        q.delete(sel);
      end else if (m_iss_v && bus.iss_ready) begin
        m_iss_v = 1'b0;
      end
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        for (int s = 0; s < NUM_SRC; s++) begin
          bc_lookup(e.tag[s*5 +: 5], bus.bc_valid, bus.bc_tag, bus.bc_data, hit, d);
          if (hit) begin
            e.val[s*32 +: 32] = d;
            e.tag[s*5 +: 5]   = INV;
          end
        end
        q[i] = e;
      end
      if (bus.in_ce && bus.in_target != INV && !full_pre) begin
        e.target = bus.in_target;
        e.op     = bus.in_op;
        e.pc     = bus.in_pc;
        e.val    = bus.in_val;
        e.tag    = bus.in_tag;
        for (int s = 0; s < NUM_SRC; s++) begin
          bc_lookup(e.tag[s*5 +: 5], bus.bc_valid, bus.bc_tag, bus.bc_data, hit, d);
          if (hit) begin
            e.val[s*32 +: 32] = d;
            e.tag[s*5 +: 5]   = INV;
          end
        end
        q.push_back(e);
      end
    end
  end

  task automatic compare_model();
    check_eq("iss_valid", 64'(bus.iss_valid), 64'(m_iss_v));
    if (m_iss_v) begin
      check_eq("iss_target", 64'(bus.iss_target), 64'(m_iss.target));
      check_eq("iss_op", 64'(bus.iss_op), 64'(m_iss.op));
      check_eq("iss_val", bus.iss_val, m_iss.val);
      check_eq("iss_pc", 64'(bus.iss_pc), 64'(m_iss.pc));
    end
    check_eq("count", 64'(bus.count), 64'(q.size()));
    check_eq("full", 64'(bus.full), 64'(q.size() == DEPTH));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle();
    bus.flush     = 1'b0;
    bus.in_ce     = 1'b0;
    bus.in_target = INV;
    bus.in_op     = '0;
    bus.in_val    = '0;
    bus.in_tag    = {INV, INV};
    bus.in_pc     = '0;
    bus.bc_valid  = '0;
    bus.bc_tag    = {INV, INV};
    bus.bc_data   = '0;
  endtask

  task automatic disp(input logic [4:0] t, input logic [9:0] tg, input logic [63:0] v);
    bus.in_ce     = 1'b1;
    bus.in_target = t;
    bus.in_op     = t[3:0];
    bus.in_tag    = tg;
    bus.in_val    = v;
    bus.in_pc     = 32'h1000 + 32'(t);
  endtask

  task automatic bcast(input logic [1:0] bv, input logic [9:0] bt, input logic [63:0] bd);
    bus.bc_valid = bv;
    bus.bc_tag   = bt;
    bus.bc_data  = bd;
  endtask

  task automatic drain();
    idle();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  initial begin
    idle();
    bus.iss_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
    check_eq("rst_iss_target", 64'(bus.iss_target), 64'(INV));
    check_eq("rst_iss_op", 64'(bus.iss_op), 64'd0);
    check_eq("rst_iss_val", bus.iss_val, 64'd0);
    check_eq("rst_iss_pc", 64'(bus.iss_pc), 64'd0);
    check_eq("rst_count", 64'(bus.count), 64'd0);
    check_eq("rst_full", 64'(bus.full), 64'd0);
    rst = 1'b0;

    // Fully ready dispatch: two edges to iss_valid
    disp(5'd3, {INV, INV}, {32'd7, 32'd5});
    step();
    idle();
    check_eq("s1_valid_e1", 64'(bus.iss_valid), 64'd0);
    step();
    check_eq("s1_valid_e2", 64'(bus.iss_valid), 64'd1);
    check_eq("s1_target", 64'(bus.iss_target), 64'd3);
    check_eq("s1_val", bus.iss_val, {32'd7, 32'd5});
    step();
    check_eq("s1_count", 64'(bus.count), 64'd0);

    // Wakeup of operand 1 by a broadcast in cycle 3
    drain();
    disp(5'd4, {5'd9, INV}, {32'd0, 32'h10});
    step();
    idle();
    step();
    step();
    bcast(2'b01, {INV, 5'd9}, {32'd0, 32'hAB});
    step();
    idle();
`ifdef RS_WAKEUP_BYPASS_EN
    check_eq("s2_valid_e4", 64'(bus.iss_valid), 64'd1);
    check_eq("s2_val1", 64'(bus.iss_val[63:32]), 64'hAB);
`else
    check_eq("s2_valid_e4", 64'(bus.iss_valid), 64'd0);
    step();
    check_eq("s2_valid_e5", 64'(bus.iss_valid), 64'd1);
    check_eq("s2_target", 64'(bus.iss_target), 64'd4);
    check_eq("s2_val1", 64'(bus.iss_val[63:32]), 64'hAB);
`endif

    // Fill, drop a dispatch while full, then release in order
    drain();
    bus.iss_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(5'(20 + i), {INV, 5'(10 + i)}, {32'(i), 32'(i)});
      step();
    end
    disp(5'd8, {INV, INV}, 64'd1);
    step();
    idle();
    check_eq("s3_full", 64'(bus.full), 64'd1);
    check_eq("s3_count", 64'(bus.count), 64'd4);
    bcast(2'b11, {5'd11, 5'd10}, {32'h11, 32'h10});
    step();
    bcast(2'b11, {5'd13, 5'd12}, {32'h13, 32'h12});
    step();
    idle();
    bus.iss_ready = 1'b1;
    order.delete();
    for (int k = 0; k < 10; k++) begin
      if (bus.iss_valid) order.push_back(int'(bus.iss_target));
      step();
    end
    check_eq("s3_order_n", 64'(order.size()), 64'd4);
    for (int i = 0; i < DEPTH; i++)
      check_eq("s3_order", 64'((i < order.size()) ? order[i] : 99), 64'(20 + i));

    // Younger B wakes first and issues first; A follows once B is accepted
    drain();
    bus.iss_ready = 1'b0;
    disp(5'd1, {INV, 5'd14}, {32'd0, 32'hA0});
    step();
    disp(5'd2, {INV, 5'd15}, {32'd0, 32'hB0});
    step();
    idle();
    bcast(2'b01, {INV, 5'd15}, {32'd0, 32'hB1});
    step();
    bcast(2'b10, {5'd14, INV}, {32'hA1, 32'd0});
    step();
    idle();
    step();
    check_eq("s4_first", 64'(bus.iss_target), 64'd2);
    bus.iss_ready = 1'b1;
    step();
    check_eq("s4_second_v", 64'(bus.iss_valid), 64'd1);
    check_eq("s4_second", 64'(bus.iss_target), 64'd1);
    check_eq("s4_second_val", 64'(bus.iss_val[31:0]), 64'hA1);
    step();

    // Same-cycle capture at dispatch
    drain();
    disp(5'd5, {INV, 5'd6}, {32'h11, 32'h0});
    bcast(2'b10, {5'd6, INV}, {32'h66, 32'd0});
    step();
    idle();
    step();
    check_eq("s5_valid", 64'(bus.iss_valid), 64'd1);
    check_eq("s5_val0", 64'(bus.iss_val[31:0]), 64'h66);

    // Flush with live entries and a same-cycle dispatch
    drain();
    bus.iss_ready = 1'b0;
    disp(5'd7, {INV, INV}, 64'd3);
    step();
    for (int i = 0; i < 3; i++) begin
      disp(5'(9 + i), {INV, 5'(16 + i)}, 64'(i));
      step();
    end
    disp(5'd12, {INV, INV}, 64'd4);
    bus.flush = 1'b1;
    step();
    idle();
    check_eq("s6_count", 64'(bus.count), 64'd0);
    check_eq("s6_valid", 64'(bus.iss_valid), 64'd0);
    check_eq("s6_full", 64'(bus.full), 64'd0);
    bus.iss_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bcast(2'b11, {5'(17 + k), 5'(16 + k)}, 64'd9);
      step();
      check_eq("s6_no_issue", 64'(bus.iss_valid), 64'd0);
    end

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      bus.flush     = ($urandom_range(0, 49) == 0);
      bus.in_ce     = ($urandom_range(0, 2) != 0);
      bus.in_target = ($urandom_range(0, 9) == 0) ? INV : 5'($urandom_range(0, 30));
      bus.in_op     = 4'($urandom);
      bus.in_val    = {$urandom, $urandom};
      bus.in_pc     = $urandom;
      for (int s = 0; s < NUM_SRC; s++)
        bus.in_tag[s*5 +: 5] = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 7)) : INV;
      bus.bc_valid = 2'($urandom);
      for (int c = 0; c < BCAST_N; c++)
        bus.bc_tag[c*5 +: 5] = ($urandom_range(0, 8) == 8) ? INV : 5'($urandom_range(0, 7));
      bus.bc_data   = {$urandom, $urandom};
      bus.iss_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
